rcv_bit_timer: RTL and testbench
================================

# rcv_bit_timer

Receive-side timing and framing controller for the serial receiver. It synchronizes the raw serial line, detects a start bit, and generates one sampling strobe per data bit at mid-bit. It then checks the stop bit and reports packet completion or a framing error. Its strobes drive the downstream shift register and its done/error pulses feed the receive buffer control.

## Interface
- CLKS_PER_BIT, default 10: clock cycles per serial bit; legal range 4..255.
- DATA_BITS, default 8: data bits per frame; legal range 1..16.
- clk  input  1  system clock, rising-edge.
- n_rst  input  1  asynchronous, active-low reset.
- serial_in  input  1  raw asynchronous serial line; idle high.
- enable  input  1  receiver enable; active high.
- shift_strobe  output  1  one-cycle pulse per sampled data bit.
- sample_data  output  1  line value sampled for the current strobe; valid while shift_strobe=1.
- packet_done  output  1  one-cycle pulse on a valid stop bit.
- framing_error  output  1  sticky flag; set on an invalid stop bit.
- parity_error  output  1  sticky flag; meaningful only with RCV_PARITY_EN.
- busy  output  1  high from start detect until the frame ends or aborts.

## Operation
- Synchronizer: 2-FF chain on serial_in; both stages reset to 1. An edge register holds the previous synchronized value and resets to 1.
- Start detect: occurs in IDLE with enable=1 when the previous synchronized value is 1 and the current one is 0 (cycle T).
- Bit-clock counter: width $clog2(CLKS_PER_BIT+1). It counts 1..CLKS_PER_BIT and wraps to 1. It is cleared on every state entry.
- Bit counter: width $clog2(DATA_BITS+1). It is cleared in IDLE and increments on each shift_strobe.
- FSM states and transitions:
  - IDLE: go to HALF on start detect.
  - HALF: wait CLKS_PER_BIT/2 cycles (integer division).
    - If the sampled line is 0, go to DATA.
    - If the sampled line is 1 (false start), go to IDLE with no outputs.
  - DATA: on each counter wrap, pulse shift_strobe with the sampled line. After the DATA_BITS-th strobe, go to PARITY (macro defined) or STOP.
  - PARITY: wait CLKS_PER_BIT cycles and sample. If (sampled bit XOR data XOR-reduction) = 1, set parity_error. Then go to STOP.
  - STOP: wait CLKS_PER_BIT cycles and sample.
    - Sample 1: pulse packet_done.
    - Sample 0: set framing_error, no packet_done.
    - Then go to IDLE.
- framing_error and parity_error clear on the next start detect that passes the HALF check.
- enable=0 in any non-IDLE state aborts to IDLE on the next edge: no strobes, no done, error flags unchanged.
- A line falling edge while not in IDLE is ignored.
- Reset values: shift_strobe=0, sample_data=0, packet_done=0, framing_error=0, parity_error=0, busy=0, FSM=IDLE.

## Timing
- All outputs are registered.
- Let H = CLKS_PER_BIT/2 and N = CLKS_PER_BIT. Synchronizer latency is 2 cycles from serial_in to detect.
- busy goes high at T+1.
- Start-bit check samples at T+H.
- Data bit k (k=0..DATA_BITS-1, LSB first) samples at T+H+(k+1)·N. shift_strobe and sample_data are high at T+H+(k+1)·N+1.
- Stop sample is at T+H+(DATA_BITS+1+P)·N, where P=1 with parity and 0 without.
- packet_done or framing_error appears one cycle after the stop sample. busy falls in the same cycle.
- Back-to-back frames: a start edge is accepted from the first IDLE cycle after the stop sample.
- Asynchronous reset mid-frame forces all outputs to reset values immediately. No pulse follows reset release until a new start detect.

## Configuration
- RCV_PARITY_EN defined: the PARITY state is included and an even-parity bit follows the data. parity_error updates as described in Operation.
- RCV_PARITY_EN undefined: the PARITY state is not built, the frame is start + data + stop, and parity_error is tied to 0.

## Test plan
- Idle line high for 100 cycles, enable=1 -> no strobes; busy=0 and all flags 0.
- CLKS_PER_BIT=10, DATA_BITS=8, frame 0xA5 with stop=1 -> 8 strobes at 10-cycle spacing, first at T+16; sample_data sequence 1,0,1,0,0,1,0,1; packet_done pulse at T+96.
- 3-cycle low glitch on an idle line -> HALF check reads 1; return to IDLE with no strobes and busy low by T+6.
- Frame 0x3C with stop=0 -> 8 strobes, framing_error=1 at T+96, no packet_done. The next valid frame 0xFF clears the flag at its start check and gives packet_done.
- enable dropped at T+40 during frame 0x55 -> FSM returns to IDLE, strobes stop, no packet_done, busy=0 at T+41.
- RCV_PARITY_EN, frame 0x07 with parity bit 0 (odd total) -> parity_error=1. Stop is sampled at T+105 and packet_done still pulses at T+106.

Source files
------------

// File: rtl/rcv_bit_timer_if.sv
// rcv_bit_timer_if: serial line in, bit strobes and frame status out.
// master = timer side, slave = line driver / strobe consumer side.
interface rcv_bit_timer_if;
  logic serial_in;
  logic enable;
  logic shift_strobe;
  logic sample_data;
  logic packet_done;
  logic framing_error;
  logic parity_error;
  logic busy;

  modport master (
    input  serial_in,
    input  enable,
    output shift_strobe,
    output sample_data,
    output packet_done,
    output framing_error,
    output parity_error,
    output busy
  );

  modport slave (
    output serial_in,
    output enable,
    input  shift_strobe,
    input  sample_data,
    input  packet_done,
    input  framing_error,
    input  parity_error,
    input  busy
  );
endinterface

// File: rtl/rcv_bit_timer.sv
// rcv_bit_timer: receive bit timing, mid-bit sampling and framing check.
// Optional even-parity stage built when RCV_PARITY_EN is defined.
module rcv_bit_timer #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input logic             clk,
  input logic             n_rst,
  rcv_bit_timer_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS + 1);

  // counter value seen in the cycle a wait ends
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    HALF,
    DATA,
`ifdef RCV_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t state_q, state_d;

  logic sync1, sync2, prev;
  logic start;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;

  logic strobe_q, strobe_d;
  logic sample_q, sample_d;
  logic done_q, done_d;
  logic ferr_q, ferr_d;
  logic busy_q, busy_d;

  logic tick_mid, tick_bit;

`ifdef RCV_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
`endif

  assign start    = bus.enable & prev & ~sync2;
  assign tick_mid = (cnt_q == CNT_MID);
  assign tick_bit = (cnt_q == CNT_BIT);

  // two-stage synchronizer plus edge history, idle-high on reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= bus.serial_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // next state, counters and next output values
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    strobe_d = 1'b0;
    sample_d = sample_q;
    done_d   = 1'b0;
    ferr_d   = ferr_q;
`ifdef RCV_PARITY_EN
    par_d    = par_q;
    perr_d   = perr_q;
`endif

    unique case (state_q)
      IDLE: begin
        bit_d = '0;
`ifdef RCV_PARITY_EN
        par_d = 1'b0;
`endif
        if (start) state_d = HALF;
      end
      HALF: begin
        if (tick_mid) begin
          if (!sync2) begin
            state_d = DATA;
            ferr_d  = 1'b0;
`ifdef RCV_PARITY_EN
            perr_d  = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick_bit) begin
          strobe_d = 1'b1;
          sample_d = sync2;
          bit_d    = bit_q + 1'b1;
`ifdef RCV_PARITY_EN
          par_d    = par_q ^ sync2;
`endif
          if (bit_q == BIT_LAST) begin
`ifdef RCV_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef RCV_PARITY_EN
      PARITY: begin
        if (tick_bit) begin
          if (sync2 ^ par_q) perr_d = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick_bit) begin
          if (sync2) done_d = 1'b1;
          else       ferr_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // disable mid-frame drops the frame silently
    if (state_q != IDLE && !bus.enable) begin
      state_d  = IDLE;
      bit_d    = bit_q;
      strobe_d = 1'b0;
      sample_d = sample_q;
      done_d   = 1'b0;
      ferr_d   = ferr_q;
`ifdef RCV_PARITY_EN
      par_d    = par_q;
      perr_d   = perr_q;
`endif
    end

    busy_d = (state_d != IDLE);

    if (state_d != state_q || state_d == IDLE) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_FULL) begin
      cnt_d = CW'(1);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // state and counter registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  // registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      strobe_q <= 1'b0;
      sample_q <= 1'b0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      strobe_q <= strobe_d;
      sample_q <= sample_d;
      done_q   <= done_d;
      ferr_q   <= ferr_d;
      busy_q   <= busy_d;
    end
  end

`ifdef RCV_PARITY_EN
  // running data parity and sticky parity flag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign bus.parity_error = perr_q;
`else
  assign bus.parity_error = 1'b0;
`endif

  assign bus.shift_strobe  = strobe_q;
  assign bus.sample_data   = sample_q;
  assign bus.packet_done   = done_q;
  assign bus.framing_error = ferr_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_rcv_bit_timer.sv
// tb_rcv_bit_timer: frame table plus scoreboard of expected strobes/done.
// Parity rows are exercised when RCV_PARITY_EN is defined.
module tb_rcv_bit_timer;

  localparam int N  = 10;
  localparam int DB = 8;
  localparam int H  = N / 2;
`ifdef RCV_PARITY_EN
  localparam int P  = 1;
`else
  localparam int P  = 0;
`endif

  typedef struct {
    logic [15:0] data;
    logic        stop;
    logic        par;
    int          abort;
    logic        exp_done;
    logic        exp_ferr;
    logic        exp_perr;
  } vec_t;

  typedef struct {
    int   cyc;
    logic val;
  } sb_t;

  logic clk = 1'b0;
  logic n_rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic model_ferr = 1'b0;
  logic model_perr = 1'b0;

  sb_t  strb_q[$];
  int   done_q[$];
  vec_t vecs[$];

  rcv_bit_timer_if bus();

  rcv_bit_timer #(
    .CLKS_PER_BIT(N),
    .DATA_BITS(DB)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endfunction

  // scoreboard: pop an expectation whenever the DUT pulses
  sb_t e;
  int  dc;
  always @(negedge clk) begin
    if (bus.shift_strobe) begin
      if (strb_q.size() == 0) begin
        chk("strobe_unexpected", 1, 0);
      end else begin
        e = strb_q.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("strobe_data", int'(bus.sample_data), int'(e.val));
      end
    end
    if (bus.packet_done) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        dc = done_q.pop_front();
        chk("done_cycle", cyc, dc);
      end
    end
  end

  task automatic run_frame(input vec_t v);
    int   total;
    int   done_rel;
    int   c0;
    int   b;
    int   rel;
    logic bitv;
    logic eperr;
    total    = (DB + 2 + P) * N + 4;
    done_rel = H + (DB + 1 + P) * N + 1;
    eperr    = (P == 1) ? v.exp_perr : 1'b0;
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int k = 0; k < DB; k++) begin
      if (v.abort == 0 || H + (k + 1) * N < v.abort)
        strb_q.push_back('{c0 + 2 + H + (k + 1) * N + 1, v.data[k]});
    end
    if (v.exp_done) done_q.push_back(c0 + 2 + done_rel);
    for (int i = 0; i < total; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      b   = i / N;
      rel = i - 2;
      if (b == 0)                      bitv = 1'b0;
      else if (b <= DB)                bitv = v.data[b-1];
      else if (P == 1 && b == DB + 1)  bitv = v.par;
      else if (b == DB + 1 + P)        bitv = v.stop;
      else                             bitv = 1'b1;
      bus.serial_in = bitv;
      if (v.abort > 0 && rel >= v.abort) bus.enable = 1'b0;
      @(negedge clk);
      if (rel == 1) chk("busy_rise", int'(bus.busy), 1);
      if (rel == H) begin
        chk("ferr_before_check", int'(bus.framing_error), int'(model_ferr));
        chk("perr_before_check", int'(bus.parity_error), int'(model_perr));
      end
      if (rel == H + 1) begin
        model_ferr = 1'b0;
        model_perr = 1'b0;
        chk("ferr_cleared", int'(bus.framing_error), 0);
        chk("perr_cleared", int'(bus.parity_error), 0);
      end
      if (v.abort == 0 && rel == done_rel - 1)
        chk("busy_before_end", int'(bus.busy), 1);
      if (v.abort == 0 && rel == done_rel) begin
        model_ferr = v.exp_ferr;
        model_perr = eperr;
        chk("busy_fall", int'(bus.busy), 0);
        chk("ferr_at_end", int'(bus.framing_error), int'(model_ferr));
        chk("perr_at_end", int'(bus.parity_error), int'(model_perr));
      end
      if (v.abort > 0 && rel == v.abort)
        chk("busy_at_abort", int'(bus.busy), 1);
      if (v.abort > 0 && rel == v.abort + 1)
        chk("busy_after_abort", int'(bus.busy), 0);
    end
    bus.serial_in = 1'b1;
    bus.enable    = 1'b1;
  endtask

  // short low pulse on an idle line: false start, no strobes
  task automatic glitch();
    @(posedge clk);
    #1;
    bus.serial_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.serial_in = 1'b1;
    @(negedge clk);
    chk("glitch_busy_t1", int'(bus.busy), 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_t5", int'(bus.busy), 1);
    @(posedge clk);
    @(negedge clk);
    chk("glitch_busy_t6", int'(bus.busy), 0);
    chk("glitch_ferr_kept", int'(bus.framing_error), int'(model_ferr));
    repeat (20) @(posedge clk);
  endtask

  initial begin
    vecs.push_back('{16'h00A5, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{16'h003C, 1'b0, 1'b0, 0,  1'b0, 1'b1, 1'b0});
    vecs.push_back('{16'h00FF, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{16'h0055, 1'b1, 1'b0, 40, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{16'h0000, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{16'h0081, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b0});
`ifdef RCV_PARITY_EN
    vecs.push_back('{16'h0007, 1'b1, 1'b0, 0,  1'b1, 1'b0, 1'b1});
    vecs.push_back('{16'h0001, 1'b1, 1'b1, 0,  1'b1, 1'b0, 1'b0});
`endif

    n_rst         = 1'b0;
    bus.serial_in = 1'b1;
    bus.enable    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobe", int'(bus.shift_strobe), 0);
    chk("rst_sample", int'(bus.sample_data), 0);
    chk("rst_done", int'(bus.packet_done), 0);
    chk("rst_ferr", int'(bus.framing_error), 0);
    chk("rst_perr", int'(bus.parity_error), 0);
    chk("rst_busy", int'(bus.busy), 0);
    n_rst = 1'b1;

    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_ferr", int'(bus.framing_error), 0);
    chk("idle_perr", int'(bus.parity_error), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_frame(vecs[i]);
      if (i == 1) glitch();
    end

    // async reset in the cycle of the first strobe of a frame
    @(posedge clk);
    #1;
    bus.serial_in = 1'b0;
    repeat (2 + H + N + 1) @(posedge clk);
    #3;
    chk("pre_reset_strobe", int'(bus.shift_strobe), 1);
    chk("pre_reset_busy", int'(bus.busy), 1);
    n_rst = 1'b0;
    #1;
    chk("async_rst_strobe", int'(bus.shift_strobe), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    bus.serial_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    model_ferr = 1'b0;
    model_perr = 1'b0;
    repeat (120) @(posedge clk);
    @(negedge clk);
    chk("post_reset_busy", int'(bus.busy), 0);
    chk("post_reset_ferr", int'(bus.framing_error), 0);

    chk("strobe_queue_empty", strb_q.size(), 0);
    chk("done_queue_empty", done_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
